// File: rtl/encounter_pkg.sv
// Shared types and constants for the encounter controller and its LFSR.
package encounter_pkg;

    localparam int SPECIES_W = 3;
    localparam int LFSR_W    = 16;

    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WINDOW,
        S_END,
        S_DONE
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] value);
        logic [LFSR_W-1:0] shifted;
        shifted = value >> 1;
        if (value[0]) begin
            shifted = shifted ^ LFSR_TAPS;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/encounter_lfsr.sv
// Free-running 16-bit Galois LFSR; only the async reset reseeds it.
module encounter_lfsr
    import encounter_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [LFSR_W-1:0] o_value
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_value <= SEED;
        end else begin
            o_value <= lfsr_step(o_value);
        end
    end

endmodule

// File: rtl/encounter_ctrl.sv
// Encounter sequencer: species draw, wait, timed capture window, verdict and refresh strobe.
module encounter_ctrl
    import encounter_pkg::*;
#(
    parameter int                WAIT_CYCLES   = 50_000_000,
    parameter int                WINDOW_CYCLES = 12_500_000,
    parameter int                NUM_ROUNDS    = 10,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1,
    parameter int                NUM_SPECIES   = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_restart,
    input  logic                 i_key,
    output logic                 o_refresh,
    output logic                 o_capture,
    output logic [SPECIES_W-1:0] o_random,
    output logic [SPECIES_W-1:0] o_species,
    output logic                 o_window,
    output logic                 o_done,
    output logic [3:0]           o_round
);

    localparam int MAX_CYCLES = (WAIT_CYCLES > WINDOW_CYCLES) ? WAIT_CYCLES : WINDOW_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [3:0]       ROUND_LAST  = 4'(NUM_ROUNDS);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             round_d;
    logic                   capture_d;
    logic [SPECIES_W-1:0]   random_d, species_d;
    logic                   finish;
    logic [LFSR_W-1:0]      lfsr_value;
    logic [SPECIES_W-1:0]   next_species;
    logic                   unused_lfsr_bits;

    encounter_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_value (lfsr_value)
    );

    assign next_species     = SPECIES_W'(int'(lfsr_value[SPECIES_W-1:0]) % NUM_SPECIES);
    assign unused_lfsr_bits = ^lfsr_value[LFSR_W-1:SPECIES_W];

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        round_d   = o_round;
        capture_d = 1'b0;
        random_d  = '0;
        species_d = o_species;
        finish    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_END;
                    random_d = next_species;
                end
            end
            S_WAIT: begin
                if (i_key) begin
                    finish = 1'b1;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_WINDOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WINDOW: begin
                if (i_key || (cnt_q == WINDOW_LAST)) begin
                    finish    = 1'b1;
                    capture_d = i_key;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_END: begin
                species_d = o_random;
                cnt_d     = '0;
                state_d   = (o_round == ROUND_LAST) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Round is counted on entry to S_END so it is visible alongside the strobe.
        if (finish) begin
            state_d  = S_END;
            cnt_d    = '0;
            round_d  = o_round + 1'b1;
            random_d = next_species;
        end

        if (i_restart) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            round_d   = '0;
            capture_d = 1'b0;
            random_d  = '0;
            species_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            o_round   <= '0;
            o_refresh <= 1'b0;
            o_capture <= 1'b0;
            o_random  <= '0;
            o_species <= '0;
            o_window  <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            o_round   <= round_d;
            o_refresh <= (state_d == S_END);
            o_capture <= capture_d;
            o_random  <= random_d;
            o_species <= species_d;
            o_window  <= (state_d == S_WINDOW);
            o_done    <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_encounter_ctrl.sv
// Directed bench for encounter_ctrl with small timing parameters and a reference LFSR.
module tb_encounter_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       restart;
    logic       key;
    logic       o_refresh;
    logic       o_capture;
    logic [2:0] o_random;
    logic [2:0] o_species;
    logic       o_window;
    logic       o_done;
    logic [3:0] o_round;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    logic [2:0]  last_random;

    encounter_ctrl #(
        .WAIT_CYCLES   (4),
        .WINDOW_CYCLES (3),
        .NUM_ROUNDS    (2),
        .LFSR_SEED     (16'hACE1),
        .NUM_SPECIES   (6)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_restart (restart),
        .i_key     (key),
        .o_refresh (o_refresh),
        .o_capture (o_capture),
        .o_random  (o_random),
        .o_species (o_species),
        .o_window  (o_window),
        .o_done    (o_done),
        .o_round   (o_round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    function automatic logic [2:0] exp_species(input logic [15:0] v);
        logic [2:0] low;
        low = v[2:0];
        if (low >= 3'd6) return low - 3'd6;
        return low;
    endfunction

    // Reference LFSR; m_prev holds the value the DUT saw in the previous cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_lfsr <= model_step(m_lfsr);
            m_prev <= m_lfsr;
        end
    end

    function automatic logic [13:0] all_outputs();
        return {o_refresh, o_capture, o_random, o_species, o_window, o_done, o_round};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; restart = 1'b0; key = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (all_outputs() !== 14'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outputs());
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (all_outputs() !== 14'd0) begin
            n_fail++; $display("FAIL idle_outputs: got %h expected 0", all_outputs());
        end
    endtask

    // Priming refresh, then four wait cycles before the window opens.
    task automatic test_start();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if ({o_refresh, o_capture, o_round} !== 6'b10_0000) begin
            n_fail++; $display("FAIL prime_strobe: got ref=%0b cap=%0b round=%0d expected 1 0 0", o_refresh, o_capture, o_round);
        end
        n_checks++;
        if (o_random !== exp_species(m_prev)) begin
            n_fail++; $display("FAIL prime_random: got %0d expected %0d", o_random, exp_species(m_prev));
        end
        last_random = exp_species(m_prev);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({o_window, o_refresh} !== 2'b00) begin
                n_fail++; $display("FAIL wait_quiet[%0d]: got win=%0b ref=%0b expected 0 0", i, o_window, o_refresh);
            end
            if (i == 0) begin
                n_checks++;
                if (o_species !== last_random) begin
                    n_fail++; $display("FAIL prime_species: got %0d expected %0d", o_species, last_random);
                end
            end
        end
        tick();
        n_checks++;
        if (o_window !== 1'b1) begin
            n_fail++; $display("FAIL window_open: got %0b expected 1", o_window);
        end
    endtask

    task automatic test_capture_hit();
        tick();
        n_checks++;
        if (o_window !== 1'b1) begin
            n_fail++; $display("FAIL hit_window2: got %0b expected 1", o_window);
        end
        key = 1'b1; tick(); key = 1'b0;
        n_checks++;
        if ({o_refresh, o_capture, o_window, o_round} !== 7'b110_0001) begin
            n_fail++; $display("FAIL hit_strobe: got ref=%0b cap=%0b win=%0b round=%0d expected 1 1 0 1", o_refresh, o_capture, o_window, o_round);
        end
        n_checks++;
        if (o_random !== exp_species(m_prev)) begin
            n_fail++; $display("FAIL hit_random: got %0d expected %0d", o_random, exp_species(m_prev));
        end
        last_random = exp_species(m_prev);
        tick();
        n_checks++;
        if ({o_refresh, o_species} !== {1'b0, last_random}) begin
            n_fail++; $display("FAIL hit_species: got ref=%0b sp=%0d expected 0 %0d", o_refresh, o_species, last_random);
        end
    endtask

    task automatic test_early_press();
        key = 1'b1; tick(); key = 1'b0;
        n_checks++;
        if ({o_refresh, o_capture, o_window, o_round} !== 7'b100_0010) begin
            n_fail++; $display("FAIL early_strobe: got ref=%0b cap=%0b win=%0b round=%0d expected 1 0 0 2", o_refresh, o_capture, o_window, o_round);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({o_window, o_refresh} !== 2'b00) begin
                n_fail++; $display("FAIL early_no_window[%0d]: got win=%0b ref=%0b expected 0 0", i, o_window, o_refresh);
            end
        end
    endtask

    task automatic test_done_restart();
        n_checks++;
        if ({o_done, o_round} !== 5'b1_0010) begin
            n_fail++; $display("FAIL done_state: got done=%0b round=%0d expected 1 2", o_done, o_round);
        end
        start = 1'b1; key = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({o_done, o_refresh, o_round} !== 6'b10_0010) begin
                n_fail++; $display("FAIL done_ignores[%0d]: got done=%0b ref=%0b round=%0d expected 1 0 2", i, o_done, o_refresh, o_round);
            end
        end
        start = 1'b0; key = 1'b0;
        restart = 1'b1; tick(); restart = 1'b0;
        n_checks++;
        if (all_outputs() !== 14'd0) begin
            n_fail++; $display("FAIL restart_outputs: got %h expected 0", all_outputs());
        end
        tick();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if ({o_refresh, o_capture, o_random} !== {2'b10, exp_species(m_prev)}) begin
            n_fail++; $display("FAIL restart_prime: got ref=%0b cap=%0b rnd=%0d expected 1 0 %0d", o_refresh, o_capture, o_random, exp_species(m_prev));
        end
    endtask

    task automatic test_timeout();
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({o_window, o_refresh} !== 2'b10) begin
                n_fail++; $display("FAIL timeout_window[%0d]: got win=%0b ref=%0b expected 1 0", i, o_window, o_refresh);
            end
        end
        tick();
        n_checks++;
        if ({o_refresh, o_capture, o_window, o_round} !== 7'b100_0001) begin
            n_fail++; $display("FAIL timeout_strobe: got ref=%0b cap=%0b win=%0b round=%0d expected 1 0 0 1", o_refresh, o_capture, o_window, o_round);
        end
    endtask

    task automatic test_terminal_key();
        repeat (6) tick();
        tick();
        n_checks++;
        if (o_window !== 1'b1) begin
            n_fail++; $display("FAIL terminal_window: got %0b expected 1", o_window);
        end
        key = 1'b1; tick(); key = 1'b0;
        n_checks++;
        if ({o_refresh, o_capture, o_round} !== 6'b11_0010) begin
            n_fail++; $display("FAIL terminal_strobe: got ref=%0b cap=%0b round=%0d expected 1 1 2", o_refresh, o_capture, o_round);
        end
        tick();
        n_checks++;
        if (o_done !== 1'b1) begin
            n_fail++; $display("FAIL terminal_done: got %0b expected 1", o_done);
        end
    endtask

    task automatic test_async_reset();
        bit opened;
        restart = 1'b1; tick(); restart = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        opened = 1'b0;
        for (int i = 0; i < 20 && !opened; i++) begin
            tick();
            opened = o_window;
        end
        n_checks++;
        if (!opened) begin
            n_fail++; $display("FAIL async_reach_window: window got 0 expected 1 within 20 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outputs() !== 14'd0) begin
            n_fail++; $display("FAIL async_immediate: got %h expected 0", all_outputs());
        end
        repeat (2) begin
            tick();
            n_checks++;
            if (all_outputs() !== 14'd0) begin
                n_fail++; $display("FAIL async_held: got %h expected 0", all_outputs());
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random_refreshes();
        int  refreshes;
        bit  prev_refresh;
        bit  need_start;
        refreshes = 0; prev_refresh = 1'b0; need_start = 1'b1;
        for (int c = 0; c < 20000 && refreshes < 1000; c++) begin
            tick();
            if (o_refresh) begin
                n_checks++;
                if (prev_refresh) begin
                    n_fail++; $display("FAIL refresh_back_to_back: got two consecutive strobes at cycle %0d expected isolated", c);
                end
                n_checks++;
                if (o_random > 3'd5) begin
                    n_fail++; $display("FAIL random_range: got %0d expected <= 5", o_random);
                end
                n_checks++;
                if (o_random !== exp_species(m_prev)) begin
                    n_fail++; $display("FAIL random_model: got %0d expected %0d", o_random, exp_species(m_prev));
                end
                refreshes++;
            end
            prev_refresh = o_refresh;
            start = 1'b0; restart = 1'b0; key = 1'b0;
            if (o_done) begin
                restart    = 1'b1;
                need_start = 1'b1;
            end else if (need_start) begin
                start      = 1'b1;
                need_start = 1'b0;
            end else begin
                key = ($urandom_range(0, 2) == 0);
            end
        end
        start = 1'b0; restart = 1'b0; key = 1'b0;
        n_checks++;
        if (refreshes < 1000) begin
            n_fail++; $display("FAIL random_count: got %0d refreshes expected 1000", refreshes);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_capture_hit();
        test_early_press();
        test_done_restart();
        test_timeout();
        test_terminal_key();
        test_async_reset();
        test_random_refreshes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
